// File: rtl/mux_bit_packer_if.sv
// Bundle of the bit-source and word-sink signals of the bit packer.
// The master modport is the surrounding system; the slave modport is the packer.
interface mux_bit_packer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic                         bit_valid;
    logic                         bit_in;
    logic                         bit_ready;
    logic                         flush;
    logic                         word_valid;
    logic                         word_ready;
    logic [WIDTH-1:0]             word_data;
    logic [$clog2(WIDTH+1)-1:0]   word_bits;
    logic [CNT_W-1:0]             words_out;

    modport master (
        output bit_valid, bit_in, flush, word_ready,
        input  bit_ready, word_valid, word_data, word_bits, words_out
    );

    modport slave (
        input  bit_valid, bit_in, flush, word_ready,
        output bit_ready, word_valid, word_data, word_bits, words_out
    );
endinterface

// File: rtl/mux_bit_packer.sv
// Packs one Z bit per accepted cycle into WIDTH-bit words with flush support,
// holding a completed word (and stalling the bit source) while the output register is busy.
module mux_bit_packer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    mux_bit_packer_if.slave  bus
);
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, acc_upd_s;
    logic [BW-1:0]    cnt_q, cnt_d, cnt_upd_s, pos_s;
    logic [WIDTH-1:0] data_q, data_d, load_data_s;
    logic [BW-1:0]    bits_q, bits_d, load_bits_s;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             accept_s, out_free_s, handoff_s, complete_s, load_s;

    assign bus.bit_ready  = (state_q == FILL);
    assign bus.word_valid = valid_q;
    assign bus.word_data  = data_q;
    assign bus.word_bits  = bits_q;
    assign bus.words_out  = words_q;

    assign accept_s   = bus.bit_valid && (state_q == FILL);
    assign out_free_s = !valid_q || bus.word_ready;
    assign handoff_s  = valid_q && bus.word_ready;
    assign pos_s      = LSB_FIRST ? cnt_q : (BW'(WIDTH - 1) - cnt_q);
    assign cnt_upd_s  = cnt_q + {{(BW-1){1'b0}}, accept_s};

    // Accumulator with the current bit merged in; flush counts a same-cycle bit
    always_comb begin
        acc_upd_s = acc_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (accept_s && (BW'(i) == pos_s)) begin
                acc_upd_s[i] = bus.bit_in;
            end else begin
                acc_upd_s[i] = acc_q[i];
            end
        end
        complete_s = (state_q == FILL) &&
                     ((accept_s && (cnt_upd_s == BW'(WIDTH))) ||
                      (bus.flush && (cnt_upd_s != {BW{1'b0}})));
    end

    // Next-state logic; HOLD keeps the finished word in acc_q/cnt_q until out_free
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        load_s      = 1'b0;
        load_data_s = acc_q;
        load_bits_s = cnt_q;
        case (state_q)
            FILL: begin
                load_data_s = acc_upd_s;
                load_bits_s = cnt_upd_s;
                if (complete_s && out_free_s) begin
                    load_s = 1'b1;
                    acc_d  = {WIDTH{1'b0}};
                    cnt_d  = {BW{1'b0}};
                end else if (complete_s) begin
                    state_d = HOLD;
                    acc_d   = acc_upd_s;
                    cnt_d   = cnt_upd_s;
                end else begin
                    acc_d = acc_upd_s;
                    cnt_d = cnt_upd_s;
                end
            end
            HOLD: begin
                if (out_free_s) begin
                    load_s  = 1'b1;
                    state_d = FILL;
                    acc_d   = {WIDTH{1'b0}};
                    cnt_d   = {BW{1'b0}};
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = FILL;
                acc_d   = {WIDTH{1'b0}};
                cnt_d   = {BW{1'b0}};
            end
        endcase
    end

    // Output register: a load replaces the current word with no bubble
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        bits_d  = bits_q;
        if (load_s) begin
            valid_d = 1'b1;
            data_d  = load_data_s;
            bits_d  = load_bits_s;
        end else if (handoff_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        words_d = words_q + {{(CNT_W-1){1'b0}}, handoff_s};
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            acc_q   <= {WIDTH{1'b0}};
            cnt_q   <= {BW{1'b0}};
            valid_q <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
            bits_q  <= {BW{1'b0}};
            words_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            bits_q  <= bits_d;
            words_q <= words_d;
        end
    end
endmodule

// File: tb/tb_mux_bit_packer.sv
// Bench for mux_bit_packer: an LSB-first/16-bit-counter build and an MSB-first/4-bit-counter
// build share one stimulus stream and are checked against a word-list model.
module tb_mux_bit_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mux_bit_packer_if #(.WIDTH(8), .CNT_W(16)) ifa ();
    mux_bit_packer_if #(.WIDTH(8), .CNT_W(4))  ifb ();

    assign ifb.bit_valid  = ifa.bit_valid;
    assign ifb.bit_in     = ifa.bit_in;
    assign ifb.flush      = ifa.flush;
    assign ifb.word_ready = ifa.word_ready;

    mux_bit_packer #(.WIDTH(8), .LSB_FIRST(1'b1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mux_bit_packer #(.WIDTH(8), .LSB_FIRST(1'b0), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Model: bits collected so far, a held finished word, the presented word, and a handoff count
    bit cur_m[$];
    bit hold_m[$];
    bit out_m[$];
    bit have_hold_m;
    bit out_valid_m;
    int count_m;

    function automatic logic [7:0] pack(input bit q[$], input bit lsb);
        logic [7:0] w;
        w = 8'h00;
        for (int k = 0; k < q.size(); k++) w[lsb ? k : 7 - k] = q[k];
        return w;
    endfunction

    function automatic void model_reset();
        cur_m.delete(); hold_m.delete(); out_m.delete();
        have_hold_m = 1'b0; out_valid_m = 1'b0; count_m = 0;
    endfunction

    function automatic void model_edge(input bit bv, input bit bi, input bit fl, input bit wr);
        bit free, hand, load;
        bit ld[$];
        free = !out_valid_m || wr;
        hand = out_valid_m && wr;
        load = 1'b0;
        if (hand) count_m++;
        if (!have_hold_m) begin
            if (bv) cur_m.push_back(bi);
            if (cur_m.size() == 8 || (fl && cur_m.size() > 0)) begin
                if (free) begin ld = cur_m; load = 1'b1; end
                else begin hold_m = cur_m; have_hold_m = 1'b1; end
                cur_m.delete();
            end
        end else if (free) begin
            ld = hold_m; load = 1'b1; have_hold_m = 1'b0; hold_m.delete();
        end
        if (load) begin out_m = ld; out_valid_m = 1'b1; end
        else if (hand) out_valid_m = 1'b0;
    endfunction

    task automatic step(input bit bv, input bit bi, input bit fl, input bit wr);
        ifa.bit_valid = bv; ifa.bit_in = bi; ifa.flush = fl; ifa.word_ready = wr;
        @(posedge clk);
        model_edge(bv, bi, fl, wr);
        #1;
    endtask

    task automatic do_reset();
        ifa.bit_valid = 1'b0; ifa.bit_in = 1'b0; ifa.flush = 1'b0; ifa.word_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        ifa.bit_valid = 1'b0; ifa.bit_in = 1'b0; ifa.flush = 1'b0; ifa.word_ready = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (ifa.word_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", ifa.word_valid); end
        n_cmp++; if (ifa.word_data !== 8'h00 || ifb.word_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%h/%h exp=00", ifa.word_data, ifb.word_data); end
        n_cmp++; if (ifa.word_bits !== 4'd0) begin n_bad++; $display("FAIL reset_bits got=%0d exp=0", ifa.word_bits); end
        n_cmp++; if (ifa.words_out !== 16'd0 || ifb.words_out !== 4'd0) begin n_bad++; $display("FAIL reset_words got=%0d/%0d exp=0", ifa.words_out, ifb.words_out); end
        rst = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (ifa.bit_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", ifa.bit_ready); end
    endtask

    task automatic test_full_word();
        logic [7:0] s;
        s = 8'h4D;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, s[i], 1'b0, 1'b1);
            if (i == 6) begin
                n_cmp++; if (ifa.word_valid !== 1'b0) begin n_bad++; $display("FAIL full_early got=%b exp=0", ifa.word_valid); end
            end
        end
        n_cmp++; if (ifa.word_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid got=%b exp=1", ifa.word_valid); end
        n_cmp++; if (ifa.word_data !== 8'h4D) begin n_bad++; $display("FAIL full_data_lsb got=%h exp=4d", ifa.word_data); end
        n_cmp++; if (ifb.word_data !== 8'hB2) begin n_bad++; $display("FAIL full_data_msb got=%h exp=b2", ifb.word_data); end
        n_cmp++; if (ifa.word_bits !== 4'd8 || ifb.word_bits !== 4'd8) begin n_bad++; $display("FAIL full_bits got=%0d/%0d exp=8", ifa.word_bits, ifb.word_bits); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (ifa.words_out !== 16'd1) begin n_bad++; $display("FAIL full_words got=%0d exp=1", ifa.words_out); end
    endtask

    task automatic test_flush();
        do_reset();
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++; if (ifa.word_valid !== 1'b1) begin n_bad++; $display("FAIL flush_valid got=%b exp=1", ifa.word_valid); end
        n_cmp++; if (ifa.word_data !== 8'h07 || ifb.word_data !== 8'hE0) begin n_bad++; $display("FAIL flush_data got=%h/%h exp=07/e0", ifa.word_data, ifb.word_data); end
        n_cmp++; if (ifa.word_bits !== 4'd3) begin n_bad++; $display("FAIL flush_bits got=%0d exp=3", ifa.word_bits); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++; if (ifa.word_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty got=%b exp=0", ifa.word_valid); end
        n_cmp++; if (ifa.words_out !== 16'd1) begin n_bad++; $display("FAIL flush_words got=%0d exp=1", ifa.words_out); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (i == 7) begin
                n_cmp++; if (ifa.word_valid !== 1'b1 || ifa.word_data !== 8'hFF) begin n_bad++; $display("FAIL bp_first got=%b/%h exp=1/ff", ifa.word_valid, ifa.word_data); end
            end
        end
        n_cmp++; if (ifa.bit_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready got=%b exp=0", ifa.bit_ready); end
        step(1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (ifa.bit_ready !== 1'b0 || ifa.word_data !== 8'hFF) begin n_bad++; $display("FAIL bp_hold_stable got=%b/%h exp=0/ff", ifa.bit_ready, ifa.word_data); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (ifa.word_valid !== 1'b1 || ifa.words_out !== 16'd1) begin n_bad++; $display("FAIL bp_hand1 got=%b/%0d exp=1/1", ifa.word_valid, ifa.words_out); end
        n_cmp++; if (ifa.bit_ready !== 1'b1 || ifa.word_data !== 8'hFF) begin n_bad++; $display("FAIL bp_release got=%b/%h exp=1/ff", ifa.bit_ready, ifa.word_data); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (ifa.word_valid !== 1'b0 || ifa.words_out !== 16'd2) begin n_bad++; $display("FAIL bp_hand2 got=%b/%0d exp=0/2", ifa.word_valid, ifa.words_out); end
    endtask

    task automatic test_async_reset();
        bit nb[$];
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (13) step(1'b1, 1'b1, 1'b0, 1'b0);
        ifa.bit_valid = 1'b0; ifa.flush = 1'b0; ifa.word_ready = 1'b0;
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (ifa.word_valid !== 1'b0 || ifa.word_data !== 8'h00 || ifa.word_bits !== 4'd0 || ifa.words_out !== 16'd0)
            begin n_bad++; $display("FAIL async_rst got=%b/%h/%0d/%0d exp=0/00/0/0", ifa.word_valid, ifa.word_data, ifa.word_bits, ifa.words_out); end
        model_reset();
        #2 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            nb.push_back(1'($urandom_range(1)));
            step(1'b1, nb[i], 1'b0, 1'b1);
        end
        n_cmp++; if (ifa.word_data !== pack(nb, 1'b1) || ifb.word_data !== pack(nb, 1'b0))
            begin n_bad++; $display("FAIL async_resume got=%h/%h exp=%h/%h", ifa.word_data, ifb.word_data, pack(nb, 1'b1), pack(nb, 1'b0)); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 1; c <= 17; c++) begin
            step(1'b1, 1'($urandom_range(1)), 1'b1, 1'b1);
            if (c == 16) begin
                n_cmp++; if (ifb.words_out !== 4'hF) begin n_bad++; $display("FAIL wrap_max got=%0d exp=15", ifb.words_out); end
            end
        end
        n_cmp++; if (ifb.words_out !== 4'h0 || ifa.words_out !== 16'd16) begin n_bad++; $display("FAIL wrap_zero got=%0d/%0d exp=0/16", ifb.words_out, ifa.words_out); end
        n_cmp++; if (ifa.word_bits !== 4'd1) begin n_bad++; $display("FAIL wrap_bits got=%0d exp=1", ifa.word_bits); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(9) < 7), 1'($urandom_range(1)), 1'($urandom_range(9) == 0), 1'($urandom_range(9) < 6));
            n_cmp++; if (ifa.word_valid !== out_valid_m || ifb.word_valid !== out_valid_m)
                begin n_bad++; $display("FAIL rnd_valid cyc=%0d got=%b/%b exp=%b", c, ifa.word_valid, ifb.word_valid, out_valid_m); end
            n_cmp++; if (ifa.bit_ready !== !have_hold_m || ifb.bit_ready !== !have_hold_m)
                begin n_bad++; $display("FAIL rnd_ready cyc=%0d got=%b/%b exp=%b", c, ifa.bit_ready, ifb.bit_ready, !have_hold_m); end
            n_cmp++; if (ifa.words_out !== 16'(count_m) || ifb.words_out !== 4'(count_m))
                begin n_bad++; $display("FAIL rnd_words cyc=%0d got=%0d/%0d exp=%0d", c, ifa.words_out, ifb.words_out, count_m); end
            if (out_valid_m) begin
                n_cmp++; if (ifa.word_data !== pack(out_m, 1'b1) || ifb.word_data !== pack(out_m, 1'b0))
                    begin n_bad++; $display("FAIL rnd_data cyc=%0d got=%h/%h exp=%h/%h", c, ifa.word_data, ifb.word_data, pack(out_m, 1'b1), pack(out_m, 1'b0)); end
                n_cmp++; if (ifa.word_bits !== 4'(out_m.size()) || ifb.word_bits !== 4'(out_m.size()))
                    begin n_bad++; $display("FAIL rnd_bits cyc=%0d got=%0d/%0d exp=%0d", c, ifa.word_bits, ifb.word_bits, out_m.size()); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_word();
        test_flush();
        test_backpressure();
        test_async_reset();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
